dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
- Data-memory stage directly downstream of the single-cycle datapath.
- Consumes the datapath's ALU result as the address and its second register-read value as the store data, plus the load/store controls from the controller.
- Runs one transaction on a req/ready memory bus with variable latency and stalls the core until it completes.
- Returns aligned, extended load data to the result mux; flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16, max BUSY cycles waiting for mem_ready before the bus error is declared (range 1..255).
- CW, 8, width of the timeout counter; must satisfy 2**CW > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- memread  input  1  current instruction is a load.
- memwrite  input  1  current instruction is a store.
- size  input  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- unsigned_ld  input  1  1 = zero-extend sub-word load, 0 = sign-extend.
- addr  input  32  byte address (datapath ALU result).
- wdata  input  32  store data (datapath rt value).
- readdata  output  32  load result to the datapath.
- stall  output  1  hold PC and block register/memory commit.
- misalign  output  1  one-cycle pulse: the access was misaligned and was dropped.
- bus_err  output  1  one-cycle pulse: the access timed out.
- mem_req  output  1  bus request.
- mem_we  output  1  bus write strobe.
- mem_addr  output  32  word address, bits [1:0] = 00.
- mem_be  output  4  byte-lane enables, little-endian (lane0 = bits 7:0).
- mem_wdata  output  32  store data replicated to the lanes.
- mem_rdata  input  32  bus read data.
- mem_ready  input  1  bus completion; valid only while mem_req = 1.

Behaviour:
- Reset values (async, reset low): state IDLE, all outputs 0, counter 0, latched address/data/size 0.
- access = memread | memwrite. If both are 1, the access is a write; the read is ignored.
- Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0.
- IDLE:
  - If access and aligned: stall = 1 combinationally in the same cycle. Latch addr, size, unsigned_ld, we and replicated wdata. Go to BUSY.
  - If access and misaligned: misalign = 1 for that cycle, stall = 0, no bus request, readdata = 0.
  - If no access: all outputs idle.
- BUSY:
  - mem_req = 1. mem_addr, mem_be, mem_we and mem_wdata come from registers and stay stable for the whole BUSY period.
  - stall = 1.
  - The counter increments each cycle.
  - On mem_ready: register the formatted load data (writes register 0), then go to DONE. Minimum latency is access cycle, then one BUSY cycle, then DONE.
  - If the counter reaches TIMEOUT without mem_ready: go to DONE with readdata = 0 and bus_err = 1 in the DONE cycle.
- DONE:
  - stall = 0 and readdata is valid from the register; the core commits in this cycle.
  - Inputs are ignored because they still belong to the same instruction.
  - Next state is IDLE unconditionally. readdata holds its value until the next DONE.
- Byte enables:
  - byte: one-hot at addr[1:0].
  - half: 0011 or 1100 selected by addr[1].
  - word: 1111.
- Store replication:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load formatting: select the lane by the latched addr[1:0], then zero- or sign-extend to 32 bits per unsigned_ld.
- mem_ready while not in BUSY: ignored.
- Reset asserted mid-BUSY: mem_req drops immediately (asynchronously) and the transaction is abandoned.

Decomposition:
- Package mem_pkg:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - state_t enum (IDLE, BUSY, DONE).
  - MEM_TIMEOUT default constant.
- Sub-module ld_align: combinational. Inputs are the rdata word, byte offset, size and unsigned flag; output is the 32-bit extended result. Reused later by any load path.

Test Plan:
- sw, addr=0x0000_0104, wdata=0xDEADBEEF, ready after 3 BUSY cycles -> mem_addr=0x104, mem_be=1111, mem_we=1 held stable; stall high 4 cycles, low in DONE.
- lb, addr=0x0000_0203, unsigned_ld=0, mem_rdata=0x80112233, ready in 1 cycle -> mem_be=1000; readdata=0xFFFFFF80 in DONE.
- lhu, addr=0x0000_0202, mem_rdata=0xBEEF1234 -> mem_be=1100, readdata=0x0000BEEF; sh of wdata 0x0000ABCD at the same address -> mem_wdata=0xABCDABCD.
- lw, addr=0x0000_0006 -> misalign pulse in the same cycle, stall=0, mem_req never asserted.
- lw with mem_ready held low, TIMEOUT=4 -> 4 BUSY cycles, then DONE with bus_err=1, readdata=0, then IDLE.
- reset pulled low in the 2nd BUSY cycle -> mem_req=0 and stall=0 immediately; after release, IDLE and the next access proceeds normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory bridge and its load path.
package mem_pkg;

  localparam int unsigned MEM_TIMEOUT = 16;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Size code 11 behaves as a word access.
  function automatic size_t decode_size(input logic [1:0] code);
    case (code)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'(4'b0001 << off);
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input size_t sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/ld_align.sv
// Load-data aligner: picks the addressed lane and zero/sign-extends to 32 bits.
module ld_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  size_t       i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory stage: runs one req/ready bus transaction per load/store and
// stalls the core until it completes, times out, or is dropped as misaligned.
module dmem_bridge
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_TIMEOUT,
  parameter int unsigned CW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nx;
  size_t         w_size;
  logic          w_access;
  logic          w_mis;
  logic          w_stall;
  logic          w_misalign;
  logic          w_latch;
  logic          w_fin_ok;
  logic          w_fin_to;
  logic [31:0]   w_ld_data;

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  size_t         r_size;
  logic          r_uns;
  logic          r_we;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [31:0]   r_readdata;
  logic          r_bus_err;

  // Gating with reset keeps stall/misalign quiet while the core is held in reset.
  assign w_size   = decode_size(size);
  assign w_access = (memread | memwrite) & reset;
  assign w_mis    = is_misaligned(w_size, addr[1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_stall    = 1'b0;
    w_misalign = 1'b0;
    w_latch    = 1'b0;
    w_fin_ok   = 1'b0;
    w_fin_to   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          if (w_mis) begin
            w_misalign = 1'b1;
          end else begin
            w_stall    = 1'b1;
            w_latch    = 1'b1;
            w_state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (mem_ready) begin
          w_fin_ok   = 1'b1;
          w_state_nx = DONE;
        end else if (r_cnt == LAST_CNT) begin
          w_fin_to   = 1'b1;
          w_state_nx = DONE;
        end
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  ld_align u_ld_align (
    .i_rdata    (mem_rdata),
    .i_off      (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_ld_data)
  );

  // Transaction context, timeout counter and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_size     <= SZ_BYTE;
      r_uns      <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_readdata <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_bus_err <= w_fin_to;
      if (w_latch) begin
        r_cnt   <= '0;
        r_addr  <= addr;
        r_size  <= w_size;
        r_uns   <= unsigned_ld;
        r_we    <= memwrite;
        r_be    <= lane_be(w_size, addr[1:0]);
        r_wdata <= replicate(w_size, wdata);
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + CW'(1);
      end
      // Stores complete with a zero result so the result mux sees a clean value.
      if (w_fin_ok)      r_readdata <= r_we ? 32'h0 : w_ld_data;
      else if (w_fin_to) r_readdata <= 32'h0;
    end
  end

  assign stall     = w_stall;
  assign misalign  = w_misalign;
  assign readdata  = w_misalign ? 32'h0 : r_readdata;
  assign bus_err   = r_bus_err;
  assign mem_req   = (r_state == BUSY);
  assign mem_we    = mem_req & r_we;
  assign mem_addr  = mem_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign mem_be    = mem_req ? r_be : 4'h0;
  assign mem_wdata = mem_req ? r_wdata : 32'h0;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: vector table driven through a result scoreboard.
module tb_dmem_bridge;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite, unsigned_ld, mem_ready;
  logic [1:0]  size;
  logic [31:0] addr, wdata, mem_rdata;
  logic [31:0] readdata, mem_addr, mem_wdata;
  logic        stall, misalign, bus_err, mem_req, mem_we;
  logic [3:0]  mem_be;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdat;
    int          lat;     // BUSY cycle in which ready is given; 0 = never
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  dmem_bridge #(.TIMEOUT(TO), .CW(8)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .size(size), .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
    .readdata(readdata), .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rdat, input int lat, input logic mis,
                              input logic [3:0] be, input logic [31:0] ewd,
                              input logic [31:0] erd, input logic err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.a = a; v.wd = wd; v.rdat = rdat;
    v.lat = lat; v.exp_mis = mis; v.exp_be = be; v.exp_wd = ewd; v.exp_rd = erd;
    v.exp_err = err;
    return v;
  endfunction

  task automatic clear_inputs();
    memread = 1'b0; memwrite = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
    addr = 32'h0; wdata = 32'h0; mem_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int   busy_n;
    exp_t e;
    @(negedge clk);
    memread = v.rd; memwrite = v.wr; size = v.sz; unsigned_ld = v.uns;
    addr = v.a; wdata = v.wd; mem_rdata = v.rdat; mem_ready = 1'b0;
    #1;
    if (v.exp_mis) begin
      check("mis_pulse", 32'(misalign), 32'h1);
      check("mis_stall", 32'(stall), 32'h0);
      check("mis_readdata", readdata, 32'h0);
      @(posedge clk); #1;
      check("mis_noreq", 32'(mem_req), 32'h0);
      clear_inputs();
      return;
    end
    check("acc_stall", 32'(stall), 32'h1);
    check("acc_nomis", 32'(misalign), 32'h0);
    e.rd  = v.exp_rd;
    e.err = v.exp_err;
    sb.push_back(e);
    busy_n = 0;
    @(posedge clk); #1;
    while (mem_req && busy_n < 40) begin
      busy_n++;
      check("busy_stall", 32'(stall), 32'h1);
      check("busy_addr", mem_addr, {v.a[31:2], 2'b00});
      check("busy_be", 32'(mem_be), 32'(v.exp_be));
      check("busy_we", 32'(mem_we), 32'(v.wr));
      if (v.wr) check("busy_wdata", mem_wdata, v.exp_wd);
      mem_ready = (busy_n == v.lat);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    check("busy_len", 32'(busy_n), 32'((v.lat != 0) ? v.lat : TO));
    check("done_stall", 32'(stall), 32'h0);
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_empty: got no entry, expected one");
    end else begin
      e = sb.pop_front();
      check("done_readdata", readdata, e.rd);
      check("done_bus_err", 32'(bus_err), 32'(e.err));
    end
    clear_inputs();
    @(posedge clk); #1;
    check("idle_noreq", 32'(mem_req), 32'h0);
    check("idle_bus_err", 32'(bus_err), 32'h0);
    check("idle_hold", readdata, e.rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // rd wr sz  uns addr          wdata         rdata         lat mis be     exp_wdata     exp_rd        err
    vecs.push_back(mk(0, 1, 2'd2, 0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,         3, 0, 4'hF, 32'hDEAD_BEEF, 32'h0,         0));
    vecs.push_back(mk(1, 0, 2'd0, 0, 32'h0000_0203, 32'h0,         32'h8011_2233, 1, 0, 4'h8, 32'h0,         32'hFFFF_FF80, 0));
    vecs.push_back(mk(1, 0, 2'd1, 1, 32'h0000_0202, 32'h0,         32'hBEEF_1234, 2, 0, 4'hC, 32'h0,         32'h0000_BEEF, 0));
    vecs.push_back(mk(0, 1, 2'd1, 0, 32'h0000_0202, 32'h0000_ABCD, 32'h0,         1, 0, 4'hC, 32'hABCD_ABCD, 32'h0,         0));
    vecs.push_back(mk(1, 0, 2'd2, 0, 32'h0000_0006, 32'h0,         32'h0,         1, 1, 4'h0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 0, 2'd2, 0, 32'h0000_0100, 32'h0,         32'h1234_5678, 0, 0, 4'hF, 32'h0,         32'h0,         1));
    vecs.push_back(mk(1, 0, 2'd0, 1, 32'h0000_0201, 32'h0,         32'h8011_2233, 2, 0, 4'h2, 32'h0,         32'h0000_0022, 0));
    vecs.push_back(mk(1, 0, 2'd1, 0, 32'h0000_0200, 32'h0,         32'h1234_8001, 1, 0, 4'h3, 32'h0,         32'hFFFF_8001, 0));
    vecs.push_back(mk(0, 1, 2'd0, 0, 32'h0000_0003, 32'h0000_00A5, 32'h0,         1, 0, 4'h8, 32'hA5A5_A5A5, 32'h0,         0));
    vecs.push_back(mk(1, 0, 2'd1, 0, 32'h0000_0201, 32'h0,         32'h0,         1, 1, 4'h0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 1, 2'd2, 0, 32'h0000_0008, 32'h1122_3344, 32'hFFFF_FFFF, 1, 0, 4'hF, 32'h1122_3344, 32'h0,         0));
    vecs.push_back(mk(1, 0, 2'd3, 0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 2, 0, 4'hF, 32'h0,         32'hCAFE_F00D, 0));
    vecs.push_back(mk(1, 0, 2'd0, 0, 32'h0000_0202, 32'h0,         32'h8011_2233, 4, 0, 4'h4, 32'h0,         32'h0000_0011, 0));

    clear_inputs();
    mem_rdata = 32'h0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_readdata", readdata, 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Stray ready while idle must not start anything.
    mem_ready = 1'b1;
    @(posedge clk); #1;
    check("stray_ready_req", 32'(mem_req), 32'h0);
    check("stray_ready_stall", 32'(stall), 32'h0);
    mem_ready = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the second BUSY cycle abandons the transaction at once.
    @(negedge clk);
    memread = 1'b1; size = 2'd2; addr = 32'h0000_0040; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    check("rb_busy1_req", 32'(mem_req), 32'h1);
    @(posedge clk); #1;
    check("rb_busy2_req", 32'(mem_req), 32'h1);
    reset = 1'b0;
    #1;
    check("rb_req_drop", 32'(mem_req), 32'h0);
    check("rb_stall_drop", 32'(stall), 32'h0);
    check("rb_be_drop", 32'(mem_be), 32'h0);
    check("rb_readdata", readdata, 32'h0);
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    check("rb_idle_req", 32'(mem_req), 32'h0);
    run_vec(mk(1, 0, 2'd2, 0, 32'h0000_0044, 32'h0, 32'h0BAD_CAFE, 2, 0, 4'hF,
               32'h0, 32'h0BAD_CAFE, 0));

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
